// File: rtl/conv_pkg.sv
// Shared constants and types for the rate-1/2, K=3 convolutional code, used by
// the encoder here and by the decoder's BMU/ACS blocks.
package conv_pkg;

   localparam int K        = 3;
   localparam int TAIL_LEN = K - 1;

   // Generator taps over {u, u(n-1), u(n-2)}
   localparam logic [K-1:0] G1 = 3'b110;
   localparam logic [K-1:0] G0 = 3'b111;

   typedef enum logic {
      DATA = 1'b0,
      TAIL = 1'b1
   } fsm_e;

   typedef logic [1:0] trellis_state_t;
   typedef logic [1:0] code_sym_t;

   // Trellis state is {u(n-2), u(n-1)}, so the taps vector reorders it.
   function automatic code_sym_t conv_code(input trellis_state_t state, input logic u);
      logic [K-1:0] taps;
      taps = {u, state[0], state[1]};
      return {^(taps & G1), ^(taps & G0)};
   endfunction

endpackage

// File: rtl/conv_enc_core.sv
// Combinational trellis step: (state, u) -> (code symbol {c1, c0}, next state).
module conv_enc_core
   import conv_pkg::*;
(
   input  logic [1:0] state_i,
   input  logic       u_i,
   output logic [1:0] code_o,
   output logic [1:0] next_o
);

   assign code_o = conv_code(state_i, u_i);
   assign next_o = {state_i[0], u_i};

endmodule

// File: rtl/conv_encoder.sv
// Rate-1/2 K=3 convolutional encoder with one-deep output register.
// Define CONV_ENC_TAIL_EN to append two zero tail symbols per frame.
module conv_encoder
   import conv_pkg::*;
#(
   parameter int FRAME_LEN = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic       in_bit,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [1:0] out_code,
   output logic       out_last,
   output logic [1:0] cur_state
);

   localparam int CNT_W = $clog2(FRAME_LEN + 1);

   fsm_e             fsm_q;
   logic [CNT_W-1:0] bit_cnt_q;
   logic [1:0]       state_q;
   logic             out_valid_q;
   logic [1:0]       out_code_q;
   logic             out_last_q;

   logic             slot_free;
   logic             accept;
   logic             frame_end;
   logic             u;
   logic [1:0]       code_d;
   logic [1:0]       state_d;

`ifdef CONV_ENC_TAIL_EN
   localparam int TW = (TAIL_LEN > 1) ? $clog2(TAIL_LEN) : 1;
   logic [TW-1:0]    tail_cnt_q;
   logic             tail_step;
   assign tail_step = (fsm_q == TAIL) && slot_free;
`endif

   assign slot_free = !out_valid_q || out_ready;
   // Held low through reset so nothing upstream sees a handshake then
   assign in_ready  = rst_n && (fsm_q == DATA) && slot_free;
   assign accept    = in_valid && in_ready;
   assign frame_end = (bit_cnt_q == CNT_W'(FRAME_LEN - 1));
   assign u         = (fsm_q == DATA) ? in_bit : 1'b0;

   conv_enc_core u_core (
      .state_i (state_q),
      .u_i     (u),
      .code_o  (code_d),
      .next_o  (state_d)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm_q       <= DATA;
         bit_cnt_q   <= '0;
         state_q     <= '0;
         out_valid_q <= 1'b0;
         out_code_q  <= '0;
         out_last_q  <= 1'b0;
`ifdef CONV_ENC_TAIL_EN
         tail_cnt_q  <= '0;
`endif
      end else if (accept) begin
         out_valid_q <= 1'b1;
         out_code_q  <= code_d;
         state_q     <= state_d;
         if (frame_end) begin
`ifdef CONV_ENC_TAIL_EN
            fsm_q      <= TAIL;
            tail_cnt_q <= '0;
            out_last_q <= 1'b0;
            bit_cnt_q  <= bit_cnt_q + CNT_W'(1);
`else
            out_last_q <= 1'b1;
            bit_cnt_q  <= '0;
`endif
         end else begin
            out_last_q <= 1'b0;
            bit_cnt_q  <= bit_cnt_q + CNT_W'(1);
         end
`ifdef CONV_ENC_TAIL_EN
      end else if (tail_step) begin
         // Zero input flushes the trellis back to state 0
         out_valid_q <= 1'b1;
         out_code_q  <= code_d;
         state_q     <= state_d;
         if (tail_cnt_q == TW'(TAIL_LEN - 1)) begin
            out_last_q <= 1'b1;
            fsm_q      <= DATA;
            bit_cnt_q  <= '0;
         end else begin
            out_last_q <= 1'b0;
            tail_cnt_q <= tail_cnt_q + TW'(1);
         end
`endif
      end else if (out_ready) begin
         out_valid_q <= 1'b0;
      end
   end

   assign out_valid = out_valid_q;
   assign out_code  = out_code_q;
   assign out_last  = out_last_q;
   assign cur_state = state_q;

endmodule

// File: tb/tb_conv_encoder.sv
// Directed and randomized-backpressure checks of conv_encoder with FRAME_LEN = 4,
// for either build of CONV_ENC_TAIL_EN.
module tb_conv_encoder;

   localparam int FL = 4;

`ifdef CONV_ENC_TAIL_EN
   localparam logic [1:0] LAST4  = 2'd0;
   localparam logic [1:0] D0_C   = 2'b00;
   localparam logic [1:0] D0_S   = 2'd0;
   localparam logic [1:0] D1_C   = 2'b11;
   localparam logic [1:0] C2_C   = 2'b11;
   localparam logic [1:0] C2_S   = 2'd1;
`else
   localparam logic [1:0] LAST4  = 2'd1;
   localparam logic [1:0] D0_C   = 2'b10;
   localparam logic [1:0] D0_S   = 2'd2;
   localparam logic [1:0] D1_C   = 2'b10;
   localparam logic [1:0] C2_C   = 2'b01;
   localparam logic [1:0] C2_S   = 2'd3;
`endif

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic       in_bit;
   logic       out_valid;
   logic       out_ready;
   logic [1:0] out_code;
   logic       out_last;
   logic [1:0] cur_state;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model state for the random run
   logic       m_valid, m_last, m_b0, m_b1, m_u, m_slot, m_rdy;
   logic [1:0] m_code;
   int         m_cnt, m_tail;

   always #5 clk = ~clk;

   conv_encoder #(.FRAME_LEN(FL)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_bit    (in_bit),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_code  (out_code),
      .out_last  (out_last),
      .cur_state (cur_state)
   );

   task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic expect_sym(input string tag, input logic [1:0] code,
                             input logic [1:0] last, input logic [1:0] st);
      chk({tag, "_vld"},   2'(out_valid), 2'd1);
      chk({tag, "_code"},  out_code, code);
      chk({tag, "_last"},  2'(out_last), last);
      chk({tag, "_state"}, cur_state, st);
   endtask

   task automatic send(input string tag, input logic b, input logic [1:0] code,
                       input logic [1:0] last, input logic [1:0] st);
      in_valid = 1'b1;
      in_bit   = b;
      #1 chk({tag, "_rdy"}, 2'(in_ready), 2'd1);
      tick();
      expect_sym(tag, code, last, st);
   endtask

`ifdef CONV_ENC_TAIL_EN
   task automatic tail_sym(input string tag, input logic [1:0] code,
                           input logic [1:0] last, input logic [1:0] st);
      #1 chk({tag, "_rdy"}, 2'(in_ready), 2'd0);
      tick();
      expect_sym(tag, code, last, st);
   endtask
`endif

   task automatic model_load(input logic uu);
      m_code  = {uu ^ m_b0, uu ^ m_b0 ^ m_b1};
      m_b1    = m_b0;
      m_b0    = uu;
      m_valid = 1'b1;
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_bit    = 1'b0;
      out_ready = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_vld",   2'(out_valid), 2'd0);
      chk("rst_code",  out_code, 2'b00);
      chk("rst_last",  2'(out_last), 2'd0);
      chk("rst_state", cur_state, 2'd0);
      chk("rst_rdy",   2'(in_ready), 2'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Frame 1,0,1,1 with no backpressure
      send("A0", 1'b1, 2'b11, 2'd0, 2'd1);
      send("A1", 1'b0, 2'b11, 2'd0, 2'd2);
      send("A2", 1'b1, 2'b10, 2'd0, 2'd1);
      send("A3", 1'b1, 2'b00, LAST4, 2'd3);
      in_valid = 1'b0;
`ifdef CONV_ENC_TAIL_EN
      tail_sym("A4", 2'b10, 2'd0, 2'd2);
      tail_sym("A5", 2'b01, 2'd1, 2'd0);
`endif
      tick();
      chk("A_idle_vld", 2'(out_valid), 2'd0);

      // Two bits of a new frame, then reset mid-frame
      send("D0", 1'b0, D0_C, 2'd0, D0_S);
      send("D1", 1'b1, D1_C, 2'd0, 2'd1);
      in_valid = 1'b0;
      rst_n    = 1'b0;
      #1;
      chk("R_vld",   2'(out_valid), 2'd0);
      chk("R_state", cur_state, 2'd0);
      chk("R_rdy",   2'(in_ready), 2'd0);
      chk("R_last",  2'(out_last), 2'd0);
      tick();
      rst_n = 1'b1;

      // Fresh frame with three cycles of backpressure after the 2nd symbol
      send("B0", 1'b1, 2'b11, 2'd0, 2'd1);
      send("B1", 1'b0, 2'b11, 2'd0, 2'd2);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_bit = i[0];
         #1;
         chk("BH_rdy",   2'(in_ready), 2'd0);
         chk("BH_vld",   2'(out_valid), 2'd1);
         chk("BH_code",  out_code, 2'b11);
         chk("BH_state", cur_state, 2'd2);
         chk("BH_last",  2'(out_last), 2'd0);
         tick();
      end
      out_ready = 1'b1;
      send("B2", 1'b1, 2'b10, 2'd0, 2'd1);
      send("B3", 1'b1, 2'b00, LAST4, 2'd3);
`ifdef CONV_ENC_TAIL_EN
      // in_valid/in_bit stay high through the tail and must be ignored
      tail_sym("C0", 2'b10, 2'd0, 2'd2);
      tail_sym("C1", 2'b01, 2'd1, 2'd0);
`endif
      send("C2", 1'b1, C2_C, 2'd0, C2_S);
      in_valid = 1'b0;

      // Random stimulus and backpressure against a cycle model
      rst_n = 1'b0;
      tick();
      rst_n   = 1'b1;
      m_valid = 1'b0; m_last = 1'b0; m_b0 = 1'b0; m_b1 = 1'b0;
      m_code  = 2'b00; m_cnt = 0; m_tail = 0;
      for (int n = 0; n < 600; n++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         in_bit    = 1'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         m_slot    = !m_valid || out_ready;
         m_rdy     = (m_tail == 0) && m_slot;
         #1 chk("E_rdy", 2'(in_ready), 2'(m_rdy));
         if (in_valid && m_rdy) begin
            m_u = in_bit;
            model_load(m_u);
            m_cnt++;
            m_last = 1'b0;
            if (m_cnt == FL) begin
               m_cnt = 0;
`ifdef CONV_ENC_TAIL_EN
               m_tail = 2;
`else
               m_last = 1'b1;
`endif
            end
         end else if (m_tail > 0 && m_slot) begin
            model_load(1'b0);
            m_tail--;
            m_last = (m_tail == 0);
         end else if (out_ready) begin
            m_valid = 1'b0;
         end
         tick();
         chk("E_vld",   2'(out_valid), 2'(m_valid));
         chk("E_state", cur_state, {m_b1, m_b0});
         if (m_valid) begin
            chk("E_code", out_code, m_code);
            chk("E_last", 2'(out_last), 2'(m_last));
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
